sfp_acc_bank: RTL

//  Special-function stage behind the output FIFO: accumulates per-lane partial sums from the MAC

---
 rtl/sfp_acc_bank.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sfp_acc_bank.sv
`default_nettype none
// ============================================================================
//  Module   : sfp_acc_bank
//  Purpose  : Multi-pass per-lane partial-sum accumulator bank with ReLU drain.
//  Revision : 1.0
// ============================================================================
module sfp_acc_bank #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 20,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [7:0]               i_n_pass,
  input  logic [ADDR_W:0]          i_n_rows,
  input  logic                     i_relu_en,
  input  logic                     i_acc_clear,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [COL*PSUM_BW-1:0]   i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [COL*ACC_BW-1:0]    o_out_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [1:0]      S_IDLE  = 2'd0;
  localparam logic [1:0]      S_ACC   = 2'd1;
  localparam logic [1:0]      S_DRAIN = 2'd2;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [1:0]              r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [7:0]              r_pass;
  logic [7:0]              r_last_pass;
  logic [ADDR_W:0]         r_last_row;
  logic                    r_relu;
  logic                    r_done;
  logic [COL*ACC_BW-1:0]   r_bank [DEPTH];

  logic                    w_xfer;
  logic                    w_row_end;
  logic                    w_pass_end;
  logic [7:0]              w_last_pass;
  logic [ADDR_W:0]         w_rows;
  logic [COL*ACC_BW-1:0]   w_cur_row;
  logic [COL*ACC_BW-1:0]   w_new_row;

  assign o_in_ready  = (r_state == S_ACC);
  assign o_out_valid = (r_state == S_DRAIN);
  assign o_busy      = (r_state == S_ACC) || (r_state == S_DRAIN);
  assign o_done      = r_done;

  assign w_xfer      = i_in_valid && (r_state == S_ACC);
  assign w_row_end   = ({1'b0, r_addr} == r_last_row);
  assign w_pass_end  = (r_pass == r_last_pass);
  assign w_cur_row   = r_bank[r_addr];

  // Zero counts mean one; oversized row counts clamp to the bank depth.
  assign w_last_pass = (i_n_pass == 8'd0) ? 8'd0 : i_n_pass - 8'd1;
  assign w_rows      = (i_n_rows == '0) ? (ADDR_W+1)'(1) :
                       (i_n_rows > C_DEPTH) ? C_DEPTH : i_n_rows;

  for (genvar k = 0; k < COL; k++) begin : g_lane
    logic signed [ACC_BW:0]   w_in_ext;
    logic signed [ACC_BW:0]   w_old_ext;
    logic signed [ACC_BW:0]   w_sum;
    logic        [ACC_BW-1:0] w_lane;

    assign w_in_ext  = {{(ACC_BW+1-PSUM_BW){i_in_data[k*PSUM_BW+PSUM_BW-1]}},
                        i_in_data[k*PSUM_BW +: PSUM_BW]};
    assign w_old_ext = {w_cur_row[k*ACC_BW+ACC_BW-1], w_cur_row[k*ACC_BW +: ACC_BW]};
    assign w_sum     = w_old_ext + w_in_ext;

    // Pass 0 overwrites; later passes add and clamp on signed overflow.
    always_comb begin
      if (r_pass == 8'd0)
        w_new_row[k*ACC_BW +: ACC_BW] = w_in_ext[ACC_BW-1:0];
      else if (w_sum[ACC_BW] != w_sum[ACC_BW-1])
        w_new_row[k*ACC_BW +: ACC_BW] = w_sum[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}}
                                                      : {1'b0, {(ACC_BW-1){1'b1}}};
      else
        w_new_row[k*ACC_BW +: ACC_BW] = w_sum[ACC_BW-1:0];
    end

    assign w_lane = w_cur_row[k*ACC_BW +: ACC_BW];
    assign o_out_data[k*ACC_BW +: ACC_BW] =
      (r_state != S_DRAIN)          ? '0 :
      (r_relu && w_lane[ACC_BW-1])  ? '0 : w_lane;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_pass      <= 8'd0;
      r_last_pass <= 8'd0;
      r_last_row  <= '0;
      r_relu      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_acc_clear) begin
        r_state <= S_IDLE;
        r_addr  <= '0;
        r_pass  <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state     <= S_ACC;
              r_addr      <= '0;
              r_pass      <= 8'd0;
              r_last_pass <= w_last_pass;
              r_last_row  <= w_rows - (ADDR_W+1)'(1);
              r_relu      <= i_relu_en;
            end
          end
          S_ACC: begin
            if (w_xfer) begin
              r_bank[r_addr] <= w_new_row;
              if (w_row_end) begin
                r_addr <= '0;
                if (w_pass_end) r_state <= S_DRAIN;
                else            r_pass  <= r_pass + 8'd1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (i_out_ready) begin
              if (w_row_end) begin
                r_state <= S_IDLE;
                r_addr  <= '0;
                r_done  <= 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
